// File: rtl/shift_left_or_right_16bit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared constants and types for the 16-bit dual-direction
//                rotator. It holds the data and amount widths, the encoding of
//                the direction select, and the data word type.
//  Revision    : 1.0  initial release
// ============================================================================
package shift_pkg;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;    // log2(WIDTH)

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef logic [WIDTH-1:0] word_t;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_left_or_right_16bit_rot_stage.sv
`default_nettype none
// ============================================================================
//  Module      : rot_stage
//  Description : One stage of the staged rotator. When en is high it rotates
//                the word by 2**K positions in the direction given by dir.
//                When en is low the word passes through unchanged.
//  Ports       : in   - word entering the stage
//                en   - stage enable (one bit of the rotate amount)
//                dir  - DIR_LEFT / DIR_RIGHT
//                out  - word leaving the stage
//  Revision    : 1.0  initial release
// ============================================================================
module rot_stage
    import shift_pkg::*;
#(
    parameter int K = 0
) (
    input  word_t in,
    input  logic  en,
    input  logic  dir,
    output word_t out
);

    localparam int c_S = 1 << K;   // distance rotated by this stage

    word_t w_left;
    word_t w_right;

    assign w_left  = {in[WIDTH-1-c_S:0], in[WIDTH-1:WIDTH-c_S]};
    assign w_right = {in[c_S-1:0],       in[WIDTH-1:c_S]};

    assign out = !en              ? in     :
                 (dir == DIR_LEFT) ? w_left : w_right;

endmodule : rot_stage
`default_nettype wire

// File: rtl/shift_left_or_right_16bit.sv
`default_nettype none
// ============================================================================
//  Module      : shift_left_or_right_16bit
//  Description : 16-bit rotator (left or right) with registered outputs. Two
//                independent datapaths compute the same rotation. One is a
//                32-entry case table and the other is a cascade of four log2
//                stages. A registered flag shows any disagreement between them.
//                Latency is one cycle, and a new operand is accepted on every
//                cycle.
//  Ports       : clk      - rising-edge clock
//                rst_n    - asynchronous active-low reset
//                a        - data operand
//                amt      - rotate distance 0..15
//                choice   - 0 = rotate right, 1 = rotate left
//                y_case   - registered result, case-table path
//                y_stage  - registered result, staged path
//                mismatch - registered flag, paths disagree
//  Revision    : 1.0  initial release
// ============================================================================
module shift_left_or_right_16bit
    import shift_pkg::*;
#(
    parameter int WIDTH_P = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  word_t            a,
    input  logic [SHW-1:0]   amt,
    input  logic             choice,
    output word_t            y_case,
    output word_t            y_stage,
    output logic             mismatch
);

    // Both datapaths are hard-wired for 16 bits.
    generate
        if (WIDTH_P != 16) begin : g_width_check
            $error("shift_left_or_right_16bit: only WIDTH=16 is supported");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Case-table datapath
    // ------------------------------------------------------------------
    word_t w_case_next;

    always_comb begin
        w_case_next = a;
        case ({choice, amt})
            // rotate right
            5'b0_0000: w_case_next = a;
            5'b0_0001: w_case_next = {a[0],    a[15:1]};
            5'b0_0010: w_case_next = {a[1:0],  a[15:2]};
            5'b0_0011: w_case_next = {a[2:0],  a[15:3]};
            5'b0_0100: w_case_next = {a[3:0],  a[15:4]};
            5'b0_0101: w_case_next = {a[4:0],  a[15:5]};
            5'b0_0110: w_case_next = {a[5:0],  a[15:6]};
            5'b0_0111: w_case_next = {a[6:0],  a[15:7]};
            5'b0_1000: w_case_next = {a[7:0],  a[15:8]};
            5'b0_1001: w_case_next = {a[8:0],  a[15:9]};
            5'b0_1010: w_case_next = {a[9:0],  a[15:10]};
            5'b0_1011: w_case_next = {a[10:0], a[15:11]};
            5'b0_1100: w_case_next = {a[11:0], a[15:12]};
            5'b0_1101: w_case_next = {a[12:0], a[15:13]};
            5'b0_1110: w_case_next = {a[13:0], a[15:14]};
            5'b0_1111: w_case_next = {a[14:0], a[15]};
            // rotate left
            5'b1_0000: w_case_next = a;
            5'b1_0001: w_case_next = {a[14:0], a[15]};
            5'b1_0010: w_case_next = {a[13:0], a[15:14]};
            5'b1_0011: w_case_next = {a[12:0], a[15:13]};
            5'b1_0100: w_case_next = {a[11:0], a[15:12]};
            5'b1_0101: w_case_next = {a[10:0], a[15:11]};
            5'b1_0110: w_case_next = {a[9:0],  a[15:10]};
            5'b1_0111: w_case_next = {a[8:0],  a[15:9]};
            5'b1_1000: w_case_next = {a[7:0],  a[15:8]};
            5'b1_1001: w_case_next = {a[6:0],  a[15:7]};
            5'b1_1010: w_case_next = {a[5:0],  a[15:6]};
            5'b1_1011: w_case_next = {a[4:0],  a[15:5]};
            5'b1_1100: w_case_next = {a[3:0],  a[15:4]};
            5'b1_1101: w_case_next = {a[2:0],  a[15:3]};
            5'b1_1110: w_case_next = {a[1:0],  a[15:2]};
            5'b1_1111: w_case_next = {a[0],    a[15:1]};
            default:   w_case_next = a;
        endcase
    end

    // ------------------------------------------------------------------
    // Staged datapath: rotate by 1, 2, 4, 8 selected by amt[0..3]
    // ------------------------------------------------------------------
    word_t w_stage [0:SHW];

    assign w_stage[0] = a;

    generate
        for (genvar k = 0; k < SHW; k++) begin : g_stage
            rot_stage #(.K(k)) u_rot_stage (
                .in  (w_stage[k]),
                .en  (amt[k]),
                .dir (choice),
                .out (w_stage[k+1])
            );
        end
    endgenerate

    word_t w_stage_next;
    assign w_stage_next = w_stage[SHW];

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    word_t r_y_case;
    word_t r_y_stage;
    logic  r_mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_case   <= '0;
            r_y_stage  <= '0;
            r_mismatch <= 1'b0;
        end else begin
            r_y_case   <= w_case_next;
            r_y_stage  <= w_stage_next;
            r_mismatch <= (w_case_next != w_stage_next);
        end
    end

    assign y_case   = r_y_case;
    assign y_stage  = r_y_stage;
    assign mismatch = r_mismatch;

endmodule : shift_left_or_right_16bit
`default_nettype wire

// File: tb/tb_shift_left_or_right_16bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_left_or_right_16bit
//  Description : Self-checking bench for shift_left_or_right_16bit. It uses
//                directed vectors, reset corner sequences and a swept run
//                that is compared against a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_left_or_right_16bit;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [3:0]  amt;
    logic        choice;
    logic [15:0] y_case;
    logic [15:0] y_stage;
    logic        mismatch;

    int checks   = 0;
    int failures = 0;

    shift_left_or_right_16bit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .amt      (amt),
        .choice   (choice),
        .y_case   (y_case),
        .y_stage  (y_stage),
        .mismatch (mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [3:0]  amt;
        logic        choice;
        logic [15:0] exp;
    } vec_t;

    // Reference rotate built from a doubled word, independent of the RTL.
    function automatic logic [15:0] model(input logic [15:0] d,
                                          input logic [3:0] n,
                                          input logic dir);
        logic [31:0] dd;
        logic [31:0] sh;
        dd = {d, d};
        if (dir) begin
            sh = dd << n;
            return sh[31:16];
        end else begin
            sh = dd >> n;
            return sh[15:0];
        end
    endfunction

    task automatic check(input string name, input logic [15:0] exp);
        checks++;
        if (y_case !== exp || y_stage !== exp || mismatch !== 1'b0) begin
            failures++;
            $display("FAIL %s: y_case=%h y_stage=%h mismatch=%b, required y=%h mismatch=0",
                     name, y_case, y_stage, mismatch, exp);
        end
    endtask

    // Drive one operand away from the edge, then sample 1 time unit after
    // the capturing edge.
    task automatic step(input logic [15:0] da, input logic [3:0] dn,
                        input logic dc, input logic [15:0] exp,
                        input string name);
        @(negedge clk);
        a = da; amt = dn; choice = dc;
        @(posedge clk);
        #1;
        check(name, exp);
    endtask

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{16'hF3FF, 4'd1,  1'b1, 16'hE7FF};
        vecs[1]  = '{16'hF3FF, 4'd4,  1'b1, 16'h3FFF};
        vecs[2]  = '{16'hF3FF, 4'd15, 1'b1, 16'hF9FF};
        vecs[3]  = '{16'hF3FF, 4'd1,  1'b0, 16'hF9FF};
        vecs[4]  = '{16'hF3FF, 4'd4,  1'b0, 16'hFF3F};
        vecs[5]  = '{16'hF3FF, 4'd8,  1'b0, 16'hFFF3};
        vecs[6]  = '{16'h0001, 4'd1,  1'b0, 16'h8000};
        vecs[7]  = '{16'h0001, 4'd4,  1'b1, 16'h0010};
        vecs[8]  = '{16'h0001, 4'd15, 1'b1, 16'h8000};
        vecs[9]  = '{16'hA5C3, 4'd0,  1'b0, 16'hA5C3};
        vecs[10] = '{16'h5A3C, 4'd0,  1'b1, 16'h5A3C};
        vecs[11] = '{16'h1234, 4'd8,  1'b1, 16'h3412};
        vecs[12] = '{16'h8001, 4'd3,  1'b0, 16'h3000};
        vecs[13] = '{16'h8001, 4'd2,  1'b1, 16'h0006};

        // Asynchronous reset, applied before any clock edge.
        a = 16'hFFFF; amt = 4'd5; choice = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("reset_async", 16'h0000);
        @(posedge clk);
        #1 check("reset_held_over_edge", 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, applied back to back.
        for (int i = 0; i < 14; i++)
            step(vecs[i].a, vecs[i].amt, vecs[i].choice, vecs[i].exp,
                 $sformatf("vec%0d", i));

        // Hold the inputs steady and confirm the outputs do not move
        // between edges.
        @(negedge clk);
        check("hold_between_edges", 16'h0006);

        // Sweep every amt/choice for a set of operands, including
        // all-zeros, all-ones and single-bit words.
        for (int p = 0; p < 48; p++) begin
            logic [15:0] op;
            if (p == 0)       op = 16'h0000;
            else if (p == 1)  op = 16'hFFFF;
            else if (p < 18)  op = 16'h0001 << (p - 2);
            else              op = 16'($urandom);
            for (int c = 0; c < 2; c++)
                for (int n = 0; n < 16; n++)
                    step(op, 4'(n), 1'(c), model(op, 4'(n), 1'(c)),
                         $sformatf("sweep a=%h amt=%0d choice=%0d", op, n, c));

            // Reset pulse in the middle of the sweep.
            if (p == 24) begin
                @(posedge clk);
                #3 rst_n = 1'b0;
                #1 check("reset_midrun", 16'h0000);
                @(negedge clk);
                a = 16'hC001; amt = 4'd1; choice = 1'b1;
                rst_n = 1'b1;
                @(posedge clk);
                #1 check("first_edge_after_reset", 16'h8003);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_shift_left_or_right_16bit
`default_nettype wire
